// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: bus writes fill a byte FIFO that a TX FSM serialises as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits, giving 8E1 frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        txd_o,
    output logic        busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Bus contract: we_i/re_i are single-cycle strobes that are always accepted;
    // there is no stall, so a push into a full FIFO is dropped and flagged.
    logic sel_data;
    logic sel_status;
    assign sel_data   = (addr_i[3:2] == 2'b00);
    assign sel_status = (addr_i[3:2] == 2'b01);

    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr_i[1:0], wdata_i[31:8]};

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;
    logic          overflow;

    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic          baud_done;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          txd_next;
    logic [31:0]   status_word;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign push_req  = we_i & sel_data;
    assign pop       = (state == ST_IDLE) & ~empty;
    // A full FIFO still accepts a push on the edge that frees a slot.
    assign push      = push_req & (~full | pop);
    assign ovf_set   = push_req & full & ~pop;
    assign ovf_clr   = we_i & sel_status & wdata_i[3];
    assign baud_done = (baud_cnt == '0);
    assign busy_o    = ~empty | (state != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parity_bit <= 1'b0;
        end else if (pop) begin
            parity_bit <= ^mem[rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        shift_reg <= mem[rd_ptr];
                        baud_cnt  <= BAUD_RELOAD;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The line is driven from a flop so the pin never sees decode glitches;
    // it trails the FSM state by one cycle.
    always_comb begin
        txd_next = 1'b1;
        case (state)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_next = parity_bit;
`endif
            default:   txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txd_o <= 1'b1;
        end else begin
            txd_o <= txd_next;
        end
    end

    always_comb begin
        status_word       = '0;
        status_word[0]    = full;
        status_word[1]    = empty;
        status_word[2]    = busy_o;
        status_word[3]    = overflow;
        status_word[15:8] = 8'(count);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= sel_status ? status_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-and-frame-timer model of the transmitter checked every cycle,
// plus directed register-map, overflow, waveform and reset scenarios and a randomized bus phase.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        txd;
  logic        busy;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .txd_o   (txd),
    .busy_o  (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // behavioural model: byte queue + time elapsed since the current frame's pop
  logic [7:0]  exp_q[$];
  int          m_t = -1;
  logic [7:0]  m_byte = 8'h0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_pop;
  bit          m_full;
  bit          m_req;

  function automatic bit model_in_flight();
    return (m_t >= 0) && (m_t < FRAME);
  endfunction

  function automatic logic model_busy();
    return (exp_q.size() != 0) || model_in_flight();
  endfunction

  function automatic logic model_txd();
    int ph;
    if (m_t < 1 || m_t > FRAME) return 1'b1;
    ph = (m_t - 1) / CPB;
    if (ph == 0) return 1'b0;
    if (ph <= 8) return m_byte[ph-1];
`ifdef UART_TX_PARITY_EN
    if (ph == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (exp_q.size() == DEPTH);
    s[1] = (exp_q.size() == 0);
    s[2] = model_busy();
    s[3] = m_ovf;
    s[15:8] = 8'(exp_q.size());
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_t = -1;
      m_ovf = 1'b0;
      m_rdata = 32'h0;
    end else begin
      m_full = (exp_q.size() == DEPTH);
      m_pop  = !model_in_flight() && (exp_q.size() != 0);
      m_req  = we && (addr[3:2] == 2'b00);
      if (re) m_rdata = (addr[3:2] == 2'b01) ? model_status() : 32'h0;
      if (m_pop) begin
        m_byte = exp_q.pop_front();
        m_t = 0;
      end else if (model_in_flight()) begin
        m_t++;
      end else begin
        m_t = -1;
      end
      if (m_req && (!m_full || m_pop)) exp_q.push_back(wdata[7:0]);
      if (m_req && m_full && !m_pop) m_ovf = 1'b1;
      else if (we && addr[3:2] == 2'b01 && wdata[3]) m_ovf = 1'b0;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("txd", 32'(txd), 32'(model_txd()));
      check("busy", 32'(busy), 32'(model_busy()));
      check("rdata", rdata, m_rdata);
    end
  end

  // driver tasks
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    re = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    re = 1'b0;
    d = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", 32'(busy), 32'h0);
  endtask

  logic [31:0] r;
`ifdef UART_TX_PARITY_EN
  logic [10:0] frame55;
`else
  logic [9:0]  frame55;
`endif

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // reset state
    check("reset_txd", 32'(txd), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    bus_read(4'h4, r);
    check("reset_status", r, 32'h0000_0002);
    bus_read(4'h0, r);
    check("read_txdata", r, 32'h0);

    // single frame waveform, hand-written bit order
`ifdef UART_TX_PARITY_EN
    frame55 = {1'b1, 1'b0, 8'h55, 1'b0};
`else
    frame55 = {1'b1, 8'h55, 1'b0};
`endif
    bus_write(4'h0, 32'h0000_0055);
    idle(1);
    check("pre_start_high", 32'(txd), 32'h1);
    idle(1);
    for (int i = 0; i < NBITS; i++) begin
      for (int j = 0; j < CPB; j++) begin
        check($sformatf("frame55_bit%0d", i), 32'(txd), 32'(frame55[i]));
        idle(1);
      end
    end
    wait_drain(200);

    // fill, overflow, clear
    bus_write(4'h0, 32'hA5);
    bus_write(4'h0, 32'h01);
    bus_write(4'h0, 32'h02);
    bus_write(4'h0, 32'h03);
    bus_write(4'h0, 32'h04);
    bus_read(4'h4, r);
    check("status_full", r, 32'h0000_0405);
    bus_write(4'h0, 32'hFF);
    bus_read(4'h5, r);
    check("status_overflow", r, 32'h0000_040D);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, r);
    check("status_ovf_clear", r, 32'h0000_0405);
    bus_write(4'h8, 32'hFFFF_FFFF);
    bus_read(4'hC, r);
    check("read_unmapped", r, 32'h0);
    wait_drain(1000);
    bus_read(4'h4, r);
    check("status_drained", r, 32'h0000_0002);

`ifdef UART_TX_PARITY_EN
    bus_write(4'h0, 32'h07);
    idle(38);
    check("parity_07", 32'(txd), 32'h1);
    wait_drain(200);
    bus_write(4'h0, 32'h03);
    idle(38);
    check("parity_03", 32'(txd), 32'h0);
    wait_drain(200);
`endif

    // reset during data bit 3 (0xF0 has bit3 = 0, so the line is low here)
    bus_write(4'h0, 32'hF0);
    bus_write(4'h0, 32'h3C);
    idle(18);
    check("bit3_low", 32'(txd), 32'h0);
    rst = 1'b1;
    #1;
    check("rst_txd_immediate", 32'(txd), 32'h1);
    check("rst_busy_immediate", 32'(busy), 32'h0);
    check("rst_rdata_immediate", rdata, 32'h0);
    idle(2);
    rst = 1'b0;
    bus_read(4'h4, r);
    check("status_after_rst", r, 32'h0000_0002);
    idle(60);
    check("no_frame_after_rst", 32'(txd), 32'h1);

    // randomized bus traffic with quiet stretches for draining
    for (int c = 0; c < 3000; c++) begin
      if ((c % 300) < 200) begin
        int sel;
        sel = $urandom_range(0, 7);
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 2) == 0);
        addr[3:2] = (sel < 4) ? 2'b00 : (sel < 6) ? 2'b01 : (sel == 6) ? 2'b10 : 2'b11;
        addr[1:0] = 2'($urandom_range(0, 3));
        wdata = $urandom;
      end else begin
        we = 1'b0;
        re = 1'b0;
      end
      @(posedge clk); #1;
    end
    we = 1'b0;
    re = 1'b0;
    wait_drain(2000);
    bus_read(4'h4, r);
    check("final_status_idle", r & 32'h0000_FF07, 32'h0000_0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
